// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the shared line-fill port.
// The arbiter takes the slave view; caches and the memory model take the master view.
interface mem_arbiter_if #(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 32
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    logic [LINE_W-1:0] ic_rdata;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [LINE_W-1:0] dc_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              arb_busy;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
        output ic_ready, ic_rdata, dc_ready, dc_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, arb_busy
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
        input  ic_ready, ic_rdata, dc_ready, dc_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, arb_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of ICache/DCache line requests onto one memory port,
// holding the port for a fixed latency and pulsing ready to the served cache.
module mem_arbiter #(
    parameter int LINE_W      = 128,
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 5
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic             OWN_IC   = 1'b0;
    localparam logic             OWN_DC   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              grant_dc;

    // Memory is line-addressed; the byte offset within a line is dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.ic_addr[3:0], bus.dc_addr[3:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IC;
            last_q  <= OWN_IC;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        grant_dc = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ic_req || bus.dc_req) begin
                    // On contention the cache not served last time wins.
                    grant_dc = bus.dc_req && (!bus.ic_req || (last_q == OWN_IC));
                    owner_d  = grant_dc;
                    last_d   = grant_dc;
                    we_d     = grant_dc && bus.dc_we;
                    addr_d   = grant_dc ? {bus.dc_addr[ADDR_W-1:4], 4'b0}
                                        : {bus.ic_addr[ADDR_W-1:4], 4'b0};
                    wdata_d  = grant_dc ? bus.dc_wdata : '0;
                    cnt_d    = CNT_INIT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req   = (state_q == BUSY);
    assign bus.mem_we    = (state_q == BUSY) && (cnt_q == '0) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ic_ready  = (state_q == RESP) && (owner_q == OWN_IC);
    assign bus.dc_ready  = (state_q == RESP) && (owner_q == OWN_DC);
    assign bus.ic_rdata  = rdata_q;
    assign bus.dc_rdata  = rdata_q;
    assign bus.arb_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised bench for mem_arbiter; expectations come from a
// transaction schedule (grant cycle + latency arithmetic), not from FSM states.
module tb_mem_arbiter;
    localparam int LW = 128;
    localparam int AW = 32;
    localparam int L  = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
    mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus1 ();

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .MEM_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave));
    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));

    // Memory contents are a fixed function of the line address.
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = {a[AW-1:4], 4'b0};
        return {b ^ 32'hA5A5_0F0F, ~b, b + 32'h1234_5678, b};
    endfunction

    assign bus.mem_rdata  = line_of(bus.mem_addr);
    assign bus1.mem_rdata = line_of(bus1.mem_addr);

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference schedule: one access at a time, granted at m_start-1.
    bit            m_act   = 1'b0;
    int            m_start = 0;
    bit            m_own   = 1'b0;
    bit            m_we    = 1'b0;
    bit            m_last  = 1'b0;
    bit            m_fresh = 1'b1;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_wdata = '0;
    logic [LW-1:0] m_rd    = '0;

    bit ic_hold = 1'b0;
    bit dc_hold = 1'b0;

    int            ic_rdy_q[$];
    int            dc_rdy_q[$];
    int            we_q[$];
    int            mreq_q[$];
    int            m1req_q[$];
    int            m1rdy_q[$];
    logic [LW-1:0] last_we_data = '0;
    logic [AW-1:0] first_maddr  = '0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clr();
        ic_rdy_q.delete(); dc_rdy_q.delete(); we_q.delete();
        mreq_q.delete(); m1req_q.delete(); m1rdy_q.delete();
    endtask

    task automatic check_cycle();
        bit in_busy, in_resp;
        in_busy = m_act && (cyc >= m_start) && (cyc <= m_start + L - 1);
        in_resp = m_act && (cyc == m_start + L);
        chk("mem_req",  bus.mem_req,  in_busy);
        chk("mem_we",   bus.mem_we,   in_busy && m_we && (cyc == m_start + L - 1));
        chk("ic_ready", bus.ic_ready, in_resp && !m_own);
        chk("dc_ready", bus.dc_ready, in_resp && m_own);
        chk("arb_busy", bus.arb_busy, in_busy || in_resp);
        chk("ic_rdata", bus.ic_rdata, m_rd);
        chk("dc_rdata", bus.dc_rdata, m_rd);
        if (in_busy) chk("mem_addr", bus.mem_addr, {m_addr[AW-1:4], 4'b0});
        if (in_busy && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        if (m_fresh) begin
            chk("rst_addr",  bus.mem_addr,  '0);
            chk("rst_wdata", bus.mem_wdata, '0);
        end
        if (bus.ic_ready) ic_rdy_q.push_back(cyc);
        if (bus.dc_ready) dc_rdy_q.push_back(cyc);
        if (bus.mem_we) begin
            we_q.push_back(cyc);
            last_we_data = bus.mem_wdata;
        end
        if (bus.mem_req) begin
            if (mreq_q.size() == 0) first_maddr = bus.mem_addr;
            mreq_q.push_back(cyc);
        end
        if (bus1.mem_req)  m1req_q.push_back(cyc);
        if (bus1.ic_ready) m1rdy_q.push_back(cyc);
        if (bus.ic_ready && !ic_hold) bus.ic_req = 1'b0;
        if (bus.dc_ready && !dc_hold) bus.dc_req = 1'b0;
        if (bus1.ic_ready) bus1.ic_req = 1'b0;
    endtask

    // Advance one clock: update the schedule from the inputs of this cycle,
    // then compare the DUT just after the edge.
    task automatic tick();
        bit idle;
        if (reset) begin
            m_act = 1'b0; m_last = 1'b0; m_rd = '0; m_fresh = 1'b1;
        end else begin
            idle = !m_act || (cyc > m_start + L);
            if (m_act && (cyc == m_start + L - 1) && !m_we) m_rd = line_of(m_addr);
            if (idle && (bus.ic_req || bus.dc_req)) begin
                m_own   = bus.dc_req && (!bus.ic_req || !m_last);
                m_last  = m_own;
                m_act   = 1'b1;
                m_start = cyc + 1;
                m_we    = m_own && bus.dc_we;
                m_addr  = m_own ? bus.dc_addr : bus.ic_addr;
                m_wdata = bus.dc_wdata;
                m_fresh = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic ic_go(input logic [AW-1:0] a);
        bus.ic_addr = a;
        bus.ic_req  = 1'b1;
    endtask

    task automatic dc_go(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] d);
        bus.dc_we    = we;
        bus.dc_addr  = a;
        bus.dc_wdata = d;
        bus.dc_req   = 1'b1;
    endtask

    task automatic do_reset();
        bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus1.ic_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr();
    endtask

    initial begin
        int t0;
        bus.ic_req = 1'b0; bus.ic_addr = '0;
        bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = '0; bus.dc_wdata = '0;
        bus1.ic_req = 1'b0; bus1.ic_addr = '0;
        bus1.dc_req = 1'b0; bus1.dc_we = 1'b0; bus1.dc_addr = '0; bus1.dc_wdata = '0;
        @(posedge clock);
        #1;
        do_reset();

        // single ICache fill
        tick();
        clr();
        t0 = cyc;
        ic_go(32'h104);
        repeat (10) tick();
        chk("t1_ic_ready_n",   ic_rdy_q.size(), 1);
        chk("t1_ic_ready_cyc", at(ic_rdy_q, 0) - t0, 6);
        chk("t1_mreq_n",       mreq_q.size(), L);
        chk("t1_mreq_first",   at(mreq_q, 0) - t0, 1);
        chk("t1_mreq_last",    at(mreq_q, L - 1) - t0, L);
        chk("t1_mem_addr",     first_maddr, 32'h100);
        chk("t1_rdata",        bus.ic_rdata, line_of(32'h100));

        // simultaneous requests after reset: DCache first
        do_reset();
        t0 = cyc;
        dc_go(1'b0, 32'h2000, '0);
        ic_go(32'h140);
        repeat (16) tick();
        chk("t2_dc_ready_cyc", at(dc_rdy_q, 0) - t0, 6);
        chk("t2_ic_ready_cyc", at(ic_rdy_q, 0) - t0, 13);
        chk("t2_ready_n",      ic_rdy_q.size() + dc_rdy_q.size(), 2);
        chk("t2_rdata",        bus.ic_rdata, line_of(32'h140));

        // DCache write-back
        clr();
        t0 = cyc;
        dc_go(1'b1, 32'h3000, {4{32'hDEADBEEF}});
        repeat (9) tick();
        chk("t3_we_n",         we_q.size(), 1);
        chk("t3_we_cyc",       at(we_q, 0) - t0, 5);
        chk("t3_wdata",        last_we_data, {4{32'hDEADBEEF}});
        chk("t3_dc_ready_cyc", at(dc_rdy_q, 0) - t0, 6);
        chk("t3_rdata_kept",   bus.dc_rdata, line_of(32'h140));

        // reset in the middle of a write abandons it
        clr();
        t0 = cyc;
        dc_go(1'b1, 32'h3010, {$urandom, $urandom, $urandom, $urandom});
        repeat (3) tick();
        reset = 1'b1;
        bus.dc_req = 1'b0;
        tick();
        reset = 1'b0;
        chk("t4_busy_after_rst", bus.arb_busy, 1'b0);
        chk("t4_mreq_after_rst", bus.mem_req, 1'b0);
        chk("t4_rdata_after_rst", bus.dc_rdata, '0);
        repeat (4) tick();
        chk("t4_no_we",    we_q.size(), 0);
        chk("t4_no_ready", dc_rdy_q.size() + ic_rdy_q.size(), 0);
        clr();
        t0 = cyc;
        ic_go(32'h180);
        dc_go(1'b0, 32'h1C0, '0);
        repeat (16) tick();
        chk("t4_dc_first", at(dc_rdy_q, 0) - t0, 6);
        chk("t4_ic_next",  at(ic_rdy_q, 0) - t0, 13);

        // both held continuously: strict alternation every 7 cycles
        clr();
        ic_hold = 1'b1;
        dc_hold = 1'b1;
        t0 = cyc;
        ic_go(32'h400);
        dc_go(1'b0, 32'h800, '0);
        repeat (30) tick();
        chk("t5_dc0", at(dc_rdy_q, 0) - t0, 6);
        chk("t5_ic0", at(ic_rdy_q, 0) - t0, 13);
        chk("t5_dc1", at(dc_rdy_q, 1) - t0, 20);
        chk("t5_ic1", at(ic_rdy_q, 1) - t0, 27);
        ic_hold = 1'b0;
        dc_hold = 1'b0;
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        repeat (10) tick();

        // single-cycle latency instance
        clr();
        t0 = cyc;
        bus1.ic_addr = 32'h20C;
        bus1.ic_req  = 1'b1;
        repeat (5) tick();
        chk("t6_mreq_n",     m1req_q.size(), 1);
        chk("t6_mreq_cyc",   at(m1req_q, 0) - t0, 1);
        chk("t6_ready_n",    m1rdy_q.size(), 1);
        chk("t6_ready_cyc",  at(m1rdy_q, 0) - t0, 2);
        chk("t6_rdata",      bus1.ic_rdata, line_of(32'h200));

        // random traffic against the schedule model
        repeat (800) begin
            reset = ($urandom_range(0, 149) == 0);
            if (!bus.ic_req) begin
                if ($urandom_range(0, 3) == 0) ic_go($urandom);
            end else if (m_act && !m_own && cyc >= m_start && cyc < m_start + L
                         && $urandom_range(0, 15) == 0) begin
                bus.ic_req = 1'b0;
            end
            if (!bus.dc_req) begin
                if ($urandom_range(0, 3) == 0)
                    dc_go(1'($urandom_range(0, 1)), $urandom,
                          {$urandom, $urandom, $urandom, $urandom});
            end else if (m_act && m_own && cyc >= m_start && cyc < m_start + L
                         && $urandom_range(0, 15) == 0) begin
                bus.dc_req = 1'b0;
            end
            tick();
        end
        reset = 1'b0;
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
